// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default baud divisor.
package uart_pkg;

  // 50 MHz core clock / 115200 baud, rounded down.
  localparam int unsigned UART_CLKS_PER_BIT_115200 = 434;

  // Receiver deframing states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser for bringing an asynchronous level into clk.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both reset to the line's idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a one-entry valid/ready holding register and
// single-cycle framing-error / overrun status pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  // Start-bit confirm point (middle of the start bit) and end-of-bit point.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             rx_s;
  rx_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       sr;
  logic             accept;
  logic             can_load;

  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  // Handshake terms: consumer takes the byte, or the holding register can take a new one.
  always_comb begin
    accept   = data_valid & data_ready;
    can_load = ~data_valid | data_ready;
  end

  // Deframing FSM, bit timing, shift register and holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      sr         <= '0;
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A delivery on this same edge overrides the clear below.
      if (accept) begin
        data_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              // Line went back high before mid-bit: treat as a glitch.
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            sr  <= {rx_s, sr[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (can_load) begin
                data       <= sr;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        BREAK: begin
          // Hold off until the line idles so a held-low line cannot retrigger.
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 8 clocks per bit.
module tb_uart_rx;

  localparam int unsigned CPB = 8;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;

  int vectors;
  int miscompares;
  int cyc;
  int e0_cyc;
  int fe_cnt;
  int ov_cnt;
  int both_cnt;
  int vrise_cnt;
  int valid_rise_cyc;

  logic [7:0] exp_q[$];

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Scoreboard: every accepted byte must match the oldest expected byte.
  initial begin
    logic       prev_valid;
    logic [7:0] exp_b;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
      if (data_valid && !prev_valid) begin
        vrise_cnt++;
        valid_rise_cyc = cyc;
      end
      if (data_valid && data_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL accept_unexpected: got byte %h, expected no byte", data);
        end else begin
          exp_b = exp_q.pop_front();
          if (data !== exp_b) begin
            miscompares++;
            $display("FAIL accept_data: got %h, expected %h", data, exp_b);
          end
        end
      end
      prev_valid = data_valid;
    end
  end

  // Drive one 8N1 frame; the line is left at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1 rx = 1'b0;
    e0_cyc = cyc + 1;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = stop_bit;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic check_queue_empty(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: got %0d bytes still pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    rx         = 1'b1;
    data_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: got %h, expected 00", data);
    end
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b, expected 0", data_valid);
    end
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_frame_err: got %b, expected 0", frame_err);
    end
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_overrun: got %b, expected 0", overrun);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_single;
    int fe0, ov0, vr0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    vr0 = vrise_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (4) @(posedge clk);
    vectors++;
    if (vrise_cnt - vr0 !== 1) begin
      miscompares++;
      $display("FAIL single_valid_count: got %0d, expected 1", vrise_cnt - vr0);
    end
    vectors++;
    if (valid_rise_cyc !== e0_cyc + 78) begin
      miscompares++;
      $display("FAIL single_latency: got %0d, expected %0d", valid_rise_cyc - e0_cyc, 78);
    end
    vectors++;
    if (fe_cnt !== fe0 || ov_cnt !== ov0) begin
      miscompares++;
      $display("FAIL single_status: got fe %0d ov %0d, expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    check_queue_empty("single_drain");
  endtask

  task automatic test_glitch;
    int fe0, vr0;
    fe0 = fe_cnt;
    vr0 = vrise_cnt;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    vectors++;
    if (vrise_cnt !== vr0) begin
      miscompares++;
      $display("FAIL glitch_valid: got %0d, expected 0", vrise_cnt - vr0);
    end
    vectors++;
    if (fe_cnt !== fe0) begin
      miscompares++;
      $display("FAIL glitch_frame_err: got %0d, expected 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_frame_err;
    int fe0, vr0;
    fe0 = fe_cnt;
    vr0 = vrise_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40) @(posedge clk);
    #1 rx = 1'b1;
    repeat (12) @(posedge clk);
    vectors++;
    if (fe_cnt - fe0 !== 1) begin
      miscompares++;
      $display("FAIL ferr_pulses: got %0d cycles, expected 1", fe_cnt - fe0);
    end
    vectors++;
    if (vrise_cnt !== vr0) begin
      miscompares++;
      $display("FAIL ferr_valid: got %0d, expected 0", vrise_cnt - vr0);
    end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (4) @(posedge clk);
    vectors++;
    if (vrise_cnt - vr0 !== 1) begin
      miscompares++;
      $display("FAIL ferr_recover: got %0d deliveries, expected 1", vrise_cnt - vr0);
    end
    check_queue_empty("ferr_drain");
  endtask

  task automatic test_overrun;
    int ov0, fe0;
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    data_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (4) @(posedge clk);
    vectors++;
    if (ov_cnt - ov0 !== 1) begin
      miscompares++;
      $display("FAIL overrun_pulses: got %0d cycles, expected 1", ov_cnt - ov0);
    end
    vectors++;
    if (fe_cnt !== fe0) begin
      miscompares++;
      $display("FAIL overrun_frame_err: got %0d, expected 0", fe_cnt - fe0);
    end
    @(negedge clk);
    vectors++;
    if (data !== 8'h11 || data_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_hold: got %h valid %b, expected 11 valid 1", data, data_valid);
    end
    @(posedge clk);
    #1 data_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_clear: got %b, expected 0", data_valid);
    end
    check_queue_empty("overrun_drain");
  endtask

  task automatic test_back_to_back;
    int ov0;
    ov0 = ov_cnt;
    data_ready = 1'b0;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    exp_q.push_back(8'hAA);
    fork
      send_frame(8'hAA, 1'b1);
      begin
        @(posedge clk);
        repeat (78) @(posedge clk);
        #1 data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (data_valid !== 1'b1 || data !== 8'hAA) begin
          miscompares++;
          $display("FAIL b2b_replace: got %h valid %b, expected AA valid 1", data, data_valid);
        end
      end
    join
    repeat (4) @(posedge clk);
    vectors++;
    if (ov_cnt !== ov0) begin
      miscompares++;
      $display("FAIL b2b_overrun: got %0d, expected 0", ov_cnt - ov0);
    end
    check_queue_empty("b2b_drain");
  endtask

  task automatic test_reset_mid;
    int vr0;
    // Leave a byte parked in the holding register so reset has something to clear.
    data_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    repeat (4) @(posedge clk);
    vectors++;
    if (data_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pending: got %b, expected 1", data_valid);
    end
    fork
      send_frame(8'hF0, 1'b1);
      begin
        @(posedge clk);
        repeat (44) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        vectors++;
        if (data !== 8'h00 || data_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL rstmid_outputs: got %h valid %b, expected 00 valid 0", data, data_valid);
        end
        vectors++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
          miscompares++;
          $display("FAIL rstmid_status: got fe %b ov %b, expected 0 0", frame_err, overrun);
        end
      end
    join
    vr0 = vrise_cnt;
    repeat (6) @(posedge clk);
    #1 data_ready = 1'b1;
    vectors++;
    if (vrise_cnt !== vr0) begin
      miscompares++;
      $display("FAIL rstmid_no_deliver: got %0d, expected 0", vrise_cnt - vr0);
    end
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    repeat (4) @(posedge clk);
    vectors++;
    if (vrise_cnt - vr0 !== 1) begin
      miscompares++;
      $display("FAIL rstmid_recover: got %0d deliveries, expected 1", vrise_cnt - vr0);
    end
    check_queue_empty("rstmid_drain");
  endtask

  task automatic test_exclusive;
    vectors++;
    if (both_cnt !== 0) begin
      miscompares++;
      $display("FAIL status_exclusive: got %0d overlapping cycles, expected 0", both_cnt);
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    fe_cnt         = 0;
    ov_cnt         = 0;
    both_cnt       = 0;
    vrise_cnt      = 0;
    valid_rise_cyc = 0;
    e0_cyc         = 0;
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the d16 board top level: takes the asynchronous `Rx` pad, synchronises it, deframes 8N1 characters and presents each byte to the core through a one-entry valid/ready holding register. Sits directly between the `Rx` pin and the core's receive input. Also flags framing errors and overruns as single-cycle pulses for status logic.

## Interface

- `CLKS_PER_BIT`, default 434: `clk` cycles per serial bit (50 MHz / 115200). Must be ≥ 4.
- `clk` input, 1 bit: the single clock. All logic is rising-edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `rx` input, 1 bit: asynchronous serial line. Idles high.
- `data` output, 8 bits: received byte. Valid while `data_valid` is high.
- `data_valid` output, 1 bit: holding register full.
- `data_ready` input, 1 bit: consumer accepts `data` on any cycle where `data_valid & data_ready`.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit samples low.
- `overrun` output, 1 bit: one-cycle pulse when a completed byte is dropped because the holding register is full.

## Operation

- `rx` passes through a 2-flop synchroniser with both flops resetting to 1. `rx_s` is its output. All FSM decisions use `rx_s` only.
- `HALF = CLKS_PER_BIT/2` uses integer division. Bit counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide. Bit index is 3 bits.
- FSM states and transitions:
  - IDLE: if `rx_s==0`, go to START with `cnt=0`.
  - START: `cnt` increments each cycle. At `cnt==HALF-1`, if `rx_s==0`, go to DATA with `cnt=0` and `bit=0`. Otherwise the low level was a glitch: return to IDLE and discard.
  - DATA: `cnt` increments. At `cnt==CLKS_PER_BIT-1`, shift in LSB-first (`sr <= {rx_s, sr[7:1]}`) and set `cnt=0`. If `bit==7`, go to STOP; otherwise increment `bit`.
  - STOP: at `cnt==CLKS_PER_BIT-1`:
    - If `rx_s==1`, deliver `sr` and go to IDLE.
    - If `rx_s==0`, pulse `frame_err`, discard the byte and go to BREAK.
  - BREAK: wait for `rx_s==1`, then go to IDLE. This prevents retriggering during a held-low line or break.
- Delivery rules:
  - If `data_valid==0`, or `data_ready==1` in the same cycle, load `data=sr` and set `data_valid=1`.
  - Otherwise, keep the old byte, drop the new one, and pulse `overrun`.
- Handshake:
  - `data_valid` clears on the edge where `data_valid & data_ready`, unless a delivery occurs on that same edge. In that case `data_valid` stays 1 and `data` takes the new byte.
  - `data` is stable while `data_valid` is high and not accepted.
- Reset values (applied at any time, including mid-frame):
  - State returns to IDLE. `cnt`, `bit` and `sr` go to 0.
  - Synchroniser flops go to 1.
  - `data` 8'h00, `data_valid` 0, `frame_err` 0, `overrun` 0.
  - A frame interrupted by reset is discarded. The receiver resynchronises on the next falling edge after IDLE is re-entered.

## Timing

- Synchroniser latency is 2 cycles.
- Let E0 be the edge on which the first synchroniser flop captures the start-bit low. The following events occur at:
  - START entry: E0+2.
  - Start-bit confirm: E0+2+HALF.
  - Data bit k sample (k=0..7): E0+2+HALF+(k+1)·CPB.
  - Stop sample: E0+2+HALF+9·CPB.
  - `data_valid`, `frame_err` or `overrun`: high in the cycle after the stop-sample edge.
- For back-to-back frames, the receiver is back in IDLE HALF cycles before the stop bit ends, so a following start bit is never missed.
- `frame_err` and `overrun` are exactly one cycle wide and mutually exclusive.

## Structure

- Package `uart_pkg`:
  - State enum: IDLE, START, DATA, STOP, BREAK.
  - Default-baud constant `UART_CLKS_PER_BIT_115200 = 434`, shared with the future transmitter.
- Sub-module `sync_2ff`: a generic single-bit 2-flop synchroniser with a reset-value parameter, instantiated for `rx` with reset value 1.
- FSM, counters, shift register and holding register stay in `uart_rx`.

## Test plan

All scenarios use `CLKS_PER_BIT=8` (HALF=4), with `data_ready` tied high unless stated.

- Send 8'hA5 with a valid stop bit -> `data=8'hA5` and `data_valid` high exactly 78 cycles after E0. `frame_err` and `overrun` stay 0.
- Apply a 2-cycle low glitch on idle `rx` -> FSM returns to IDLE. No `data_valid`, no `frame_err`.
- Send 8'h3C with the stop bit driven low, then hold `rx` low 40 cycles, then release -> one `frame_err` pulse and no `data_valid`. No restart until `rx` returns high. A following 8'h81 frame is received correctly.
- With `data_ready=0`, send 8'h11 then 8'h22 back-to-back -> `data` holds 8'h11, one `overrun` pulse at the second stop sample. Raising `data_ready` clears `data_valid` next cycle.
- Assert `data_ready` on the exact cycle the next byte completes (8'h55 pending, 8'hAA arriving) -> `data_valid` stays 1, `data=8'hAA`, no `overrun`.
- Assert `rst` for 1 cycle in mid-DATA of an 8'hF0 frame -> all outputs return to reset values the next cycle. That frame is never delivered. A subsequent clean 8'h0F frame is received.
